reorder_buffer: RTL and testbench
=================================

# reorder_buffer

- In-order retirement queue for the R10K-style out-of-order core. Sits between dispatch and the map table.
- Dispatch allocates one entry per instruction, carrying the new tag T, the old tag T_old and the architectural destination.
- The CDB marks entries complete.
- The head entry retires in program order through `ROB_MT_PACKET`, so the map table returns T_old to its free list.
- `interrupt` squashes every in-flight entry.

## Interface
Parameters:
- `ROB_SZ`, default 32: number of entries; must be a power of two.
- `ROB_IDX_W`, default `$clog2(ROB_SZ)`: width of an entry index.

Ports:
- `clock`  in  1: the single clock. Reset is synchronous and active-high, sampled on `posedge clock`.
- `reset`  in  1: synchronous, active-high reset.
- `dispatch_en`  in  1: allocate an entry this cycle.
- `dispatch_t`  in  `TAG`: new physical tag for the destination.
- `dispatch_t_old`  in  `TAG`: previous mapping of the destination.
- `dispatch_arch_idx`  in  5: architectural destination register.
- `dispatch_has_dest`  in  1: 0 for stores, branches and other instructions with no destination.
- `dispatch_ready`  out  1: at least one entry is free.
- `dispatch_rob_idx`  out  `ROB_IDX_W`: index that an accepted dispatch receives (the tail).
- `cdb_en`  in  1: a completion is being broadcast.
- `cdb_rob_idx`  in  `ROB_IDX_W`: index of the completing entry.
- `interrupt`  in  1: flush all entries.
- `rob_mt_packet`  out  `ROB_MT_PACKET`: fields `retire_en`, `retire_t`, `retire_t_old`, `retire_arch_idx`.
- `count`  out  `ROB_IDX_W+1`: number of occupied entries.

## Operation
Storage and pointers:
- Entry fields: `valid`, `complete`, `t`, `t_old`, `arch_idx`, `has_dest`.
- `head` and `tail` are `ROB_IDX_W`-bit pointers that wrap modulo `ROB_SZ`.
- `count` is held in a separate register; full when `count == ROB_SZ`, empty when `count == 0`.

Dispatch:
- `dispatch_ready = (count != ROB_SZ)`. This signal does not depend on a same-cycle retire, so there is no combinational path from retire to dispatch.
- A dispatch is accepted when `dispatch_en && dispatch_ready && !interrupt`.
- On acceptance, at the edge: write the entry at `tail` with `valid=1`, `complete=0`, then `tail <= tail+1`.
- `dispatch_en` while not ready is ignored. It is the producer's error and the bench flags it.

Completion:
- When `cdb_en` is high and the entry at `cdb_rob_idx` is valid, set `complete=1` at the edge.
- A completion aimed at an invalid entry is ignored.

Retire (combinational from the head, at most one per cycle):
- `retire_en = entry[head].valid && entry[head].complete && !interrupt`.
- `retire_t` and `retire_t_old` carry the stored tags. Their `.valid` equals `has_dest`, so the map table frees nothing for entries with no destination.
- `retire_arch_idx` carries the stored architectural register.
- When `retire_en` is high, at the edge: `entry[head].valid <= 0`, `head <= head+1`.

Count update:
- `count` increments on dispatch only, decrements on retire only, and is unchanged when both occur.

Simultaneous events:
- A CDB completion to the current head in the same cycle is not visible to retire until the next cycle.
- A dispatch into the slot freed by a same-cycle retire is impossible, because `dispatch_ready` was already low when full.

Interrupt:
- Forces `retire_en=0` in the same cycle and drops any same-cycle dispatch or CDB write.
- At the edge: all `valid`/`complete` bits cleared, `head = tail = 0`, `count = 0`.
- Map-table recovery is the map table's job.

Reset:
- Same effect as interrupt.
- After reset: `dispatch_ready=1`, `dispatch_rob_idx=0`, `count=0`, every `rob_mt_packet` field 0.
- Reset asserted mid-operation discards all entries with no retire.

## Timing
- Dispatch at edge N: the entry is visible from cycle N+1 and `count` reflects it at N+1.
- CDB at edge N: `complete` is set at N+1. If the entry is at the head, `retire_en` is high throughout cycle N+1 and the head advances at edge N+2.
- Minimum dispatch-to-retire latency is 2 edges: dispatch at edge N, CDB in the cycle after.
- Sustained throughput: one dispatch and one retire per cycle.
- `rob_mt_packet` is combinational from registered state only. It never depends combinationally on `dispatch_*` or `cdb_*`.

## Structure
- Shared package: `TAG` (`phys_reg`, `valid`, `ready`), `ROB_MT_PACKET`, `PHYS_REG_SZ`, `ROB_SZ` default, and a new `ROB_ENTRY` struct.
- A single module; no sub-module is needed.
- The entry array is a `ROB_ENTRY [ROB_SZ-1:0]` register file with a single write port per field group.

## Test plan
- Reset, then dispatch 3 entries (T=33,34,35; T_old=1,2,3): `count=3`, `dispatch_rob_idx` = 0,1,2 then 3, `retire_en=0`.
- CDB idx 1, then idx 0: no retire after idx 1 alone. After idx 0 completes, retires appear on consecutive cycles with `retire_t_old` = 1 then 2. Entry 2 stays.
- Fill to 32 entries: `dispatch_ready=0`, a 33rd `dispatch_en` is ignored. Retire one: `dispatch_ready=1` the next cycle. `tail` wraps to 0.
- Same cycle: dispatch plus retire of the head: `count` unchanged, head and tail both advance.
- Entry with `dispatch_has_dest=0` retires with `retire_en=1` and `retire_t_old.valid=0`.
- `interrupt` with 5 entries, head complete: `retire_en=0` that cycle. Next cycle `count=0`, `dispatch_rob_idx=0`, a stale CDB to idx 2 is ignored.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared tag, map-table packet and ROB entry types
package reorder_buffer_pkg;
  localparam int PHYS_REG_SZ = 64;
  localparam int PHYS_REG_W = $clog2(PHYS_REG_SZ);
  localparam int ROB_SZ_DEFAULT = 32;
  typedef struct packed {
    logic [PHYS_REG_W-1:0] phys_reg;
    logic valid;
    logic ready;
  } TAG;
  typedef struct packed {
    logic retire_en;
    TAG retire_t;
    TAG retire_t_old;
    logic [4:0] retire_arch_idx;
  } ROB_MT_PACKET;
  typedef struct packed {
    logic valid;
    logic complete;
    TAG t;
    TAG t_old;
    logic [4:0] arch_idx;
    logic has_dest;
  } ROB_ENTRY;
endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue between dispatch and the map table
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SZ = ROB_SZ_DEFAULT,
  parameter int ROB_IDX_W = $clog2(ROB_SZ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dispatch_en,
  input  TAG                   dispatch_t,
  input  TAG                   dispatch_t_old,
  input  logic [4:0]           dispatch_arch_idx,
  input  logic                 dispatch_has_dest,
  output logic                 dispatch_ready,
  output logic [ROB_IDX_W-1:0] dispatch_rob_idx,
  input  logic                 cdb_en,
  input  logic [ROB_IDX_W-1:0] cdb_rob_idx,
  input  logic                 interrupt,
  output ROB_MT_PACKET         rob_mt_packet,
  output logic [ROB_IDX_W:0]   count
);
  ROB_ENTRY [ROB_SZ-1:0] rob;
  ROB_ENTRY head_e;
  logic [ROB_IDX_W-1:0] head, tail;
  logic accept, retire_en;
  assign head_e = rob[head];
  assign dispatch_ready = count != (ROB_IDX_W+1)'(ROB_SZ);
  assign dispatch_rob_idx = tail;
  assign accept = dispatch_en && dispatch_ready && !interrupt;
  // reset is folded in so a mid-operation reset discards entries without retiring them
  assign retire_en = head_e.valid && head_e.complete && !interrupt && !reset;
  // retire packet is built only from registered head state; the map table sees zeros when idle
  always_comb begin
    rob_mt_packet = '0;
    rob_mt_packet.retire_en = retire_en;
    if (retire_en) begin
      rob_mt_packet.retire_t = head_e.t;
      rob_mt_packet.retire_t.valid = head_e.has_dest;
      rob_mt_packet.retire_t_old = head_e.t_old;
      rob_mt_packet.retire_t_old.valid = head_e.has_dest;
      rob_mt_packet.retire_arch_idx = head_e.arch_idx;
    end
  end
  // entry array, pointers and occupancy; interrupt behaves exactly like reset
  always_ff @(posedge clock) begin
    if (reset || interrupt) begin
      for (int i = 0; i < ROB_SZ; i++) begin
        rob[i].valid <= 1'b0;
        rob[i].complete <= 1'b0;
      end
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (cdb_en && rob[cdb_rob_idx].valid) rob[cdb_rob_idx].complete <= 1'b1;
      if (retire_en) begin
        rob[head].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (accept) begin
        rob[tail] <= '{valid: 1'b1, complete: 1'b0, t: dispatch_t, t_old: dispatch_t_old,
                       arch_idx: dispatch_arch_idx, has_dest: dispatch_has_dest};
        tail <= tail + 1'b1;
      end
      count <= count + (ROB_IDX_W+1)'(accept) - (ROB_IDX_W+1)'(retire_en);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed plus random stimulus checked against a queue model
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;
  localparam int SZ = 32;
  logic clk = 1'b0;
  logic reset, dispatch_en, dispatch_has_dest, dispatch_ready, cdb_en, interrupt;
  TAG dispatch_t, dispatch_t_old;
  logic [4:0] dispatch_arch_idx, dispatch_rob_idx, cdb_rob_idx;
  ROB_MT_PACKET rob_mt_packet;
  logic [5:0] count;
  int errors = 0, checks = 0;
  typedef struct {
    int idx;
    TAG t;
    TAG t_old;
    logic [4:0] arch;
    logic hd;
    bit done;
  } ent_t;
  ent_t q[$];
  int tail_m = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clock(clk), .reset(reset), .dispatch_en(dispatch_en), .dispatch_t(dispatch_t),
    .dispatch_t_old(dispatch_t_old), .dispatch_arch_idx(dispatch_arch_idx),
    .dispatch_has_dest(dispatch_has_dest), .dispatch_ready(dispatch_ready),
    .dispatch_rob_idx(dispatch_rob_idx), .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx),
    .interrupt(interrupt), .rob_mt_packet(rob_mt_packet), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit de, input int t, input int to, input int arch, input bit hd,
                      input bit ce, input int ci, input bit intr, input bit rs);
    ROB_MT_PACKET exp;
    bit exp_ready;
    ent_t e;
    @(negedge clk);
    reset = rs;
    interrupt = intr;
    dispatch_en = de;
    dispatch_t = '{phys_reg: 6'(t), valid: 1'b1, ready: ^6'(t)};
    dispatch_t_old = '{phys_reg: 6'(to), valid: 1'b1, ready: ^6'(to)};
    dispatch_arch_idx = 5'(arch);
    dispatch_has_dest = hd;
    cdb_en = ce;
    cdb_rob_idx = 5'(ci);
    #1;
    exp = '0;
    if (q.size() > 0 && q[0].done && !intr && !rs) begin
      exp.retire_en = 1'b1;
      exp.retire_t = q[0].t;
      exp.retire_t.valid = q[0].hd;
      exp.retire_t_old = q[0].t_old;
      exp.retire_t_old.valid = q[0].hd;
      exp.retire_arch_idx = q[0].arch;
    end
    exp_ready = q.size() != SZ;
    if (!rs) begin
      chk("dispatch_ready", 64'(dispatch_ready), 64'(exp_ready));
      chk("dispatch_rob_idx", 64'(dispatch_rob_idx), 64'(tail_m));
      chk("count", 64'(count), 64'(q.size()));
    end
    chk("rob_mt_packet", 64'(rob_mt_packet), 64'(exp));
    @(posedge clk);
    if (rs || intr) begin
      q.delete();
      tail_m = 0;
    end else begin
      if (ce) foreach (q[i]) if (q[i].idx == ci) q[i].done = 1'b1;
      if (exp.retire_en) void'(q.pop_front());
      if (de && exp_ready) begin
        e.idx = tail_m; e.t = dispatch_t; e.t_old = dispatch_t_old;
        e.arch = dispatch_arch_idx; e.hd = hd; e.done = 1'b0;
        q.push_back(e);
        tail_m = (tail_m + 1) % SZ;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ci;
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    for (int i = 0; i < 3; i++) step(1, 33 + i, 1 + i, 1 + i, 1, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(); idle(); idle();
    for (int i = 0; i < 31; i++) step(1, 10 + i, 40 + i, i, 1, 0, 0, 0, 0);
    step(1, 63, 62, 7, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0);
    idle();
    idle();
    step(0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(1, 50, 51, 9, 1, 0, 0, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 20, 21, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(); idle();
    for (int i = 0; i < 5; i++) step(1, 30 + i, 5 + i, i, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 2, 0, 0);
    idle();
    step(1, 11, 12, 3, 1, 0, 0, 0, 0);
    idle();
    for (int n = 0; n < 800; n++) begin
      ci = (q.size() > 0 && $urandom_range(3) != 0) ? q[$urandom_range(q.size() - 1)].idx
                                                    : int'($urandom_range(SZ - 1));
      step($urandom_range(3) != 0, int'($urandom_range(63)), int'($urandom_range(63)),
           int'($urandom_range(31)), $urandom_range(4) != 0,
           (n % 200 < 100) ? $urandom_range(5) == 0 : $urandom_range(1) == 1, ci,
           $urandom_range(150) == 0, $urandom_range(300) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
